// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, select codes and FSM state encoding for the 8-bit CPU
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_MOV  = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_NOT  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_NOP2 = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_NOT  = 3'd5;
    localparam logic [2:0] ALU_PASS = 3'd6;

    localparam logic [2:0] MUX1_GPRF    = 3'd0;
    localparam logic [2:0] MUX1_ISR1    = 3'd1;
    localparam logic [2:0] MUX1_ISR2    = 3'd2;
    localparam logic [2:0] MUX1_ARGREG1 = 3'd3;
    localparam logic [2:0] MUX1_ARGREG2 = 3'd4;
    localparam logic [2:0] MUX1_PC      = 3'd5;
    localparam logic [2:0] MUX1_IR      = 3'd6;
    localparam logic [2:0] MUX1_SP      = 3'd7;

    localparam logic [1:0] MUX2_ALU  = 2'd0;
    localparam logic [1:0] MUX2_BUS1 = 2'd1;
    localparam logic [1:0] MUX2_RAM  = 2'd2;
    localparam logic [1:0] MUX2_ZERO = 2'd3;

    typedef enum logic [2:0] {
        S_F0   = 3'd0,
        S_F1   = 3'd1,
        S_DEC  = 3'd2,
        S_E0   = 3'd3,
        S_E1   = 3'd4,
        S_E2   = 3'd5,
        S_HALT = 3'd6
    } state_t;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational classification of the instruction register
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [7:0] ir,
    output logic [3:0] opcode,
    output logic       is_alu,
    output logic       is_mov,
    output logic       is_operand,
    output logic       is_mem,
    output logic       is_branch,
    output logic       is_halt,
    output logic [2:0] alu_op,
    output logic [1:0] rd,
    output logic [1:0] rs
);

    always_comb begin
        opcode     = ir[7:4];
        rd         = ir[3:2];
        rs         = ir[1:0];
        is_alu     = 1'b0;
        is_mov     = 1'b0;
        is_operand = 1'b0;
        is_mem     = 1'b0;
        is_branch  = 1'b0;
        is_halt    = 1'b0;
        alu_op     = ALU_PASS;
        case (ir[7:4])
            OP_ADD: begin is_alu = 1'b1; alu_op = ALU_ADD; end
            OP_SUB: begin is_alu = 1'b1; alu_op = ALU_SUB; end
            OP_AND: begin is_alu = 1'b1; alu_op = ALU_AND; end
            OP_OR:  begin is_alu = 1'b1; alu_op = ALU_OR;  end
            OP_XOR: begin is_alu = 1'b1; alu_op = ALU_XOR; end
            OP_NOT: begin is_alu = 1'b1; alu_op = ALU_NOT; end
            OP_MOV: is_mov = 1'b1;
            OP_LDI, OP_JMP: is_operand = 1'b1;
            OP_LD, OP_ST: begin
                is_operand = 1'b1;
                is_mem     = 1'b1;
            end
            OP_JZ, OP_JC: begin
                is_operand = 1'b1;
                is_branch  = 1'b1;
            end
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle fetch/decode/execute FSM driving the 8-bit datapath
module control_unit
    import cpu_pkg::*;
#(
    parameter int ZF_BIT = 0,
    parameter int CF_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ir_out,
    input  logic [7:0] alu_flags,
    output logic       load_R0,
    output logic       load_R1,
    output logic       load_R2,
    output logic       load_R3,
    output logic [1:0] gprf_sel_read,
    output logic [1:0] gprf_sel_write,
    output logic       inc_PC,
    output logic       load_PC,
    output logic       load_Add_R,
    output logic       load_Reg_Y,
    output logic       load_Reg_Z,
    output logic       load_IR,
    output logic [2:0] alu_select,
    output logic [2:0] Mux_1_sel,
    output logic [1:0] Mux_2_sel,
    output logic       mem_write,
    output logic       halted
);

    state_t     state, next_state;
    logic       zf, cf;
    logic [3:0] load_r;

    logic [3:0] opcode;
    logic       is_alu, is_mov, is_operand, is_mem, is_branch, is_halt;
    logic [2:0] alu_op;
    logic [1:0] rd, rs;
    logic       taken;
    logic       unused_flags;

    instr_decoder u_decoder (
        .ir         (ir_out),
        .opcode     (opcode),
        .is_alu     (is_alu),
        .is_mov     (is_mov),
        .is_operand (is_operand),
        .is_mem     (is_mem),
        .is_branch  (is_branch),
        .is_halt    (is_halt),
        .alu_op     (alu_op),
        .rd         (rd),
        .rs         (rs)
    );

    assign unused_flags = ^alu_flags;
    // Branches look only at the registered flags, never the live ALU outputs
    assign taken = ((opcode == OP_JZ) && zf) || ((opcode == OP_JC) && cf);

    assign load_R0 = load_r[0];
    assign load_R1 = load_r[1];
    assign load_R2 = load_r[2];
    assign load_R3 = load_r[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_F0;
            zf    <= 1'b0;
            cf    <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_E1 && is_alu) begin
                zf <= alu_flags[ZF_BIT];
                cf <= alu_flags[CF_BIT];
            end
        end
    end

    always_comb begin
        next_state     = state;
        load_r         = 4'b0000;
        gprf_sel_read  = 2'd0;
        gprf_sel_write = 2'd0;
        inc_PC         = 1'b0;
        load_PC        = 1'b0;
        load_Add_R     = 1'b0;
        load_Reg_Y     = 1'b0;
        load_Reg_Z     = 1'b0;
        load_IR        = 1'b0;
        alu_select     = ALU_ADD;
        Mux_1_sel      = MUX1_GPRF;
        Mux_2_sel      = MUX2_ALU;
        mem_write      = 1'b0;
        halted         = 1'b0;

        case (state)
            S_F0: begin
                Mux_1_sel  = MUX1_PC;
                Mux_2_sel  = MUX2_BUS1;
                load_Add_R = 1'b1;
                next_state = S_F1;
            end
            S_F1: begin
                Mux_2_sel  = MUX2_RAM;
                load_IR    = 1'b1;
                inc_PC     = 1'b1;
                next_state = S_DEC;
            end
            S_DEC: begin
                if (is_halt)
                    next_state = S_HALT;
                else if (is_alu || is_mov || is_operand)
                    next_state = S_E0;
                else
                    next_state = S_F0;
            end
            S_E0: begin
                next_state = S_F0;
                if (is_alu) begin
                    gprf_sel_read = rd;
                    Mux_2_sel     = MUX2_BUS1;
                    load_Reg_Y    = 1'b1;
                    next_state    = S_E1;
                end else if (is_mov) begin
                    gprf_sel_read  = rs;
                    Mux_2_sel      = MUX2_BUS1;
                    load_r         = 4'b0001 << rd;
                    gprf_sel_write = rd;
                end else if (is_branch && !taken) begin
                    inc_PC = 1'b1;
                end else if (is_operand) begin
                    Mux_1_sel  = MUX1_PC;
                    Mux_2_sel  = MUX2_BUS1;
                    load_Add_R = 1'b1;
                    next_state = S_E1;
                end
            end
            S_E1: begin
                next_state = S_F0;
                if (is_alu) begin
                    gprf_sel_read  = rs;
                    alu_select     = alu_op;
                    Mux_2_sel      = MUX2_ALU;
                    load_r         = 4'b0001 << rd;
                    gprf_sel_write = rd;
                    load_Reg_Z     = 1'b1;
                end else if (is_mem) begin
                    Mux_2_sel  = MUX2_RAM;
                    load_Add_R = 1'b1;
                    inc_PC     = 1'b1;
                    next_state = S_E2;
                end else if (opcode == OP_LDI) begin
                    Mux_2_sel      = MUX2_RAM;
                    load_r         = 4'b0001 << rd;
                    gprf_sel_write = rd;
                    inc_PC         = 1'b1;
                end else if (is_operand) begin
                    Mux_2_sel = MUX2_RAM;
                    load_PC   = 1'b1;
                end
            end
            S_E2: begin
                next_state = S_F0;
                if (opcode == OP_LD) begin
                    Mux_2_sel      = MUX2_RAM;
                    load_r         = 4'b0001 << rd;
                    gprf_sel_write = rd;
                end else if (opcode == OP_ST) begin
                    gprf_sel_read = rs;
                    Mux_1_sel     = MUX1_GPRF;
                    mem_write     = 1'b1;
                end
            end
            S_HALT: begin
                halted     = 1'b1;
                next_state = S_HALT;
            end
            default: next_state = S_F0;
        endcase

        // Reset masks every strobe immediately so an aborted instruction writes nothing
        if (rst) begin
            load_r         = 4'b0000;
            gprf_sel_read  = 2'd0;
            gprf_sel_write = 2'd0;
            inc_PC         = 1'b0;
            load_PC        = 1'b0;
            load_Add_R     = 1'b0;
            load_Reg_Y     = 1'b0;
            load_Reg_Z     = 1'b0;
            load_IR        = 1'b0;
            alu_select     = ALU_ADD;
            Mux_1_sel      = MUX1_GPRF;
            Mux_2_sel      = MUX2_ALU;
            mem_write      = 1'b0;
            halted         = 1'b0;
        end
    end

endmodule
